dpram_port_arbiter: RTL and testbench

Round-robin arbiter that shares one single-port SRAM macro between two independent requester ports (A and B), presenting each as its own port. It sits in the dpram subsystem between the two clients and the RAM macro. Both ports use a valid/ready request handshake with a fixed-latency, tagged read-return pipeline. Everything runs on a single clock; the arbiter does not generate or use any derived clocks.

---
 rtl/dpram_port_arbiter.sv | 79 +++++++
 tb/tb_dpram_port_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_port_arbiter.sv
// dpram_port_arbiter: round-robin sharing of one single-port SRAM between two
// valid/ready request ports, with tagged in-order read returns.
module dpram_port_arbiter #(
  parameter int AW = 8,
  parameter int DW = 16,
  parameter int RAM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  output logic          ram_ce,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);
  logic               last_b;
  logic               gnt_a;
  logic               gnt_b;
  logic [AW-1:0]      addr_q;
  logic [DW-1:0]      wdata_q;
  logic [RAM_LAT-1:0] tag_v;
  logic [RAM_LAT-1:0] tag_b;
  logic               rv_a;
  logic               rv_b;
  logic               ret_a;
  logic               ret_b;
  always_comb begin
    gnt_a = a_valid & (~b_valid | last_b);
    gnt_b = b_valid & (~a_valid | ~last_b);
  end
  assign a_ready   = gnt_a & ~rst;
  assign b_ready   = gnt_b & ~rst;
  assign ram_ce    = a_ready | b_ready;
  assign ram_we    = a_ready ? a_we : (b_ready & b_we);
  assign ram_addr  = a_ready ? a_addr : b_ready ? b_addr : addr_q;
  assign ram_wdata = a_ready ? a_wdata : b_ready ? b_wdata : wdata_q;
  // Responses are gated so nothing accepted before a reset is ever returned.
  assign a_rvalid  = rv_a & ~rst;
  assign b_rvalid  = rv_b & ~rst;
  assign ret_a     = tag_v[RAM_LAT-1] & ~tag_b[RAM_LAT-1];
  assign ret_b     = tag_v[RAM_LAT-1] & tag_b[RAM_LAT-1];
  always_ff @(posedge clk) begin
    if (rst) begin
      last_b  <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
      tag_v   <= '0;
      tag_b   <= '0;
      rv_a    <= 1'b0;
      rv_b    <= 1'b0;
      a_rdata <= '0;
      b_rdata <= '0;
    end else begin
      if (ram_ce) last_b <= b_ready;
      addr_q  <= ram_addr;
      wdata_q <= ram_wdata;
      tag_v   <= RAM_LAT'({tag_v, ram_ce & ~ram_we});
      tag_b   <= RAM_LAT'({tag_b, b_ready});
      rv_a    <= ret_a;
      rv_b    <= ret_b;
      if (ret_a) a_rdata <= ram_rdata;
      if (ret_b) b_rdata <= ram_rdata;
    end
  end
endmodule

// File: tb/tb_dpram_port_arbiter.sv
// tb_dpram_port_arbiter: table vectors, corner sequences and random traffic
// against one arbiter instance per SRAM latency (1..4), checked by a reference model.
module tb_dpram_port_arbiter;
  logic        clk = 0;
  logic        rst;
  logic        a_valid, a_we, b_valid, b_we;
  logic [7:0]  a_addr, b_addr;
  logic [15:0] a_wdata, b_wdata;
  logic        a_ready_v [4];
  logic        b_ready_v [4];
  logic        a_rvalid_v [4];
  logic        b_rvalid_v [4];
  logic [15:0] a_rdata_v [4];
  logic [15:0] b_rdata_v [4];
  logic        ram_ce_v [4];
  logic        ram_we_v [4];
  logic [7:0]  ram_addr_v [4];
  logic [15:0] ram_wdata_v [4];
  logic [15:0] ram_rdata_v [4];
  int n_checks = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 4; g++) begin : g_lat
    logic [15:0] mem [256] = '{default: 16'h0};
    logic [15:0] pipe [g+1];
    dpram_port_arbiter #(.AW(8), .DW(16), .RAM_LAT(g+1)) dut (
      .clk(clk), .rst(rst),
      .a_valid(a_valid), .a_ready(a_ready_v[g]), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_rvalid(a_rvalid_v[g]), .a_rdata(a_rdata_v[g]),
      .b_valid(b_valid), .b_ready(b_ready_v[g]), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_rvalid(b_rvalid_v[g]), .b_rdata(b_rdata_v[g]),
      .ram_ce(ram_ce_v[g]), .ram_we(ram_we_v[g]), .ram_addr(ram_addr_v[g]),
      .ram_wdata(ram_wdata_v[g]), .ram_rdata(ram_rdata_v[g])
    );
    always @(posedge clk) begin
      if (ram_ce_v[g] && ram_we_v[g]) mem[ram_addr_v[g]] <= ram_wdata_v[g];
      pipe[0] <= mem[ram_addr_v[g]];
      for (int i = 1; i <= g; i++) pipe[i] <= pipe[i-1];
    end
    assign ram_rdata_v[g] = pipe[g];
  end
  // reference model: memory image, grant history and per-latency expected rdata
  logic [15:0] m_mem [256] = '{default: 16'h0};
  logic        h_v [2048] = '{default: 1'b0};
  logic        h_b [2048];
  logic [15:0] h_d [2048];
  logic [15:0] m_ard [4] = '{default: 16'h0};
  logic [15:0] m_brd [4] = '{default: 16'h0};
  logic        m_last_b = 1'b1;
  logic [7:0]  m_addr = 8'h0;
  logic [15:0] m_wd = 16'h0;
  int          cyc = 0;
  logic        s_ar, s_br, s_ce, s_we;
  logic [7:0]  s_addr;
  logic        s_arv [4];
  logic        s_brv [4];
  logic [15:0] s_ard [4];
  logic [15:0] s_brd [4];
  typedef struct {
    logic a_v; logic a_we; logic [7:0] a_addr; logic [15:0] a_wd;
    logic b_v; logic b_we; logic [7:0] b_addr; logic [15:0] b_wd;
    logic e_ar; logic e_br; logic e_ce; logic e_we; logic [7:0] e_addr;
    logic e_arv; logic e_brv; logic [15:0] e_rd;
  } vec_t;
  vec_t tv [13];
  task automatic chk(input string nm, input int l, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (lat/row %0d, cycle %0d): got %0h expected %0h", nm, l, cyc, act, exp);
    end
  endtask
  task automatic drive(input logic r, input logic av, input logic awe, input logic [7:0] aa,
                       input logic [15:0] awd, input logic bv, input logic bwe,
                       input logic [7:0] ba, input logic [15:0] bwd);
    rst = r; a_valid = av; a_we = awe; a_addr = aa; a_wdata = awd;
    b_valid = bv; b_we = bwe; b_addr = ba; b_wdata = bwd;
  endtask
  task automatic tick();
    logic ga, gb, h, ew, erva, ervb;
    logic [7:0] ea;
    logic [15:0] ed;
    int idx;
    #3;
    ga = !rst && a_valid && (!b_valid || m_last_b);
    gb = !rst && b_valid && (!a_valid || !m_last_b);
    h = ga || gb;
    ew = ga ? a_we : gb ? b_we : 1'b0;
    ea = ga ? a_addr : gb ? b_addr : m_addr;
    ed = ga ? a_wdata : gb ? b_wdata : m_wd;
    for (int l = 0; l < 4; l++) begin
      chk("a_ready", l+1, a_ready_v[l], ga);
      chk("b_ready", l+1, b_ready_v[l], gb);
      chk("ram_ce", l+1, ram_ce_v[l], h);
      chk("ram_we", l+1, ram_we_v[l], ew);
      chk("ram_addr", l+1, ram_addr_v[l], ea);
      chk("ram_wdata", l+1, ram_wdata_v[l], ed);
      idx = cyc - l - 2;
      erva = 1'b0;
      ervb = 1'b0;
      if (idx >= 0 && h_v[idx]) begin
        if (h_b[idx]) begin ervb = !rst; m_brd[l] = h_d[idx]; end
        else begin erva = !rst; m_ard[l] = h_d[idx]; end
      end
      chk("a_rvalid", l+1, a_rvalid_v[l], erva);
      chk("b_rvalid", l+1, b_rvalid_v[l], ervb);
      if (!rst) begin
        chk("a_rdata", l+1, a_rdata_v[l], m_ard[l]);
        chk("b_rdata", l+1, b_rdata_v[l], m_brd[l]);
      end
      s_arv[l] = a_rvalid_v[l];
      s_brv[l] = b_rvalid_v[l];
      s_ard[l] = a_rdata_v[l];
      s_brd[l] = b_rdata_v[l];
    end
    s_ar = a_ready_v[0]; s_br = b_ready_v[0]; s_ce = ram_ce_v[0]; s_we = ram_we_v[0];
    s_addr = ram_addr_v[0];
    if (rst) begin
      for (int i = 0; i <= cyc; i++) h_v[i] = 1'b0;
      m_ard = '{default: 16'h0};
      m_brd = '{default: 16'h0};
      m_last_b = 1'b1; m_addr = 8'h0; m_wd = 16'h0;
    end else if (h) begin
      m_last_b = gb; m_addr = ea; m_wd = ed;
      if (ew) m_mem[ea] = ed;
      else begin h_v[cyc] = 1'b1; h_b[cyc] = gb; h_d[cyc] = m_mem[ea]; end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [7:0] pa_addr, pb_addr, ra_addr, rb_addr;
    logic [15:0] ra_wd, rb_wd;
    logic ra_v, rb_v, ra_we, rb_we, r;
    int na, nb, cnt [4];
    logic prev_b;
    tv[0]  = '{1,0,8'h01,16'h0,    1,0,8'h02,16'h0, 1,0,1,0,8'h01, 0,0,16'h0};
    tv[1]  = '{0,0,8'h00,16'h0,    1,0,8'h02,16'h0, 0,1,1,0,8'h02, 0,0,16'h0};
    tv[2]  = '{1,1,8'h05,16'h1234, 0,0,8'h00,16'h0, 1,0,1,1,8'h05, 1,0,16'h0};
    tv[3]  = '{1,0,8'h05,16'h0,    0,0,8'h00,16'h0, 1,0,1,0,8'h05, 0,1,16'h0};
    tv[4]  = '{0,0,8'h00,16'h0,    0,0,8'h00,16'h0, 0,0,0,0,8'h05, 0,0,16'h0};
    tv[5]  = '{0,0,8'h00,16'h0,    0,0,8'h00,16'h0, 0,0,0,0,8'h05, 1,0,16'h1234};
    tv[6]  = '{1,0,8'h20,16'h0,    1,0,8'h21,16'h0, 0,1,1,0,8'h21, 0,0,16'h0};
    tv[7]  = '{1,0,8'h20,16'h0,    0,0,8'h00,16'h0, 1,0,1,0,8'h20, 0,0,16'h0};
    tv[8]  = '{0,0,8'h00,16'h0,    1,1,8'h30,16'hAAAA, 0,1,1,1,8'h30, 0,1,16'h0};
    tv[9]  = '{1,1,8'h10,16'hBEEF, 1,0,8'h10,16'h0, 1,0,1,1,8'h10, 1,0,16'h0};
    tv[10] = '{0,0,8'h00,16'h0,    1,0,8'h10,16'h0, 0,1,1,0,8'h10, 0,0,16'h0};
    tv[11] = '{0,0,8'h00,16'h0,    0,0,8'h00,16'h0, 0,0,0,0,8'h10, 0,0,16'h0};
    tv[12] = '{0,0,8'h00,16'h0,    0,0,8'h00,16'h0, 0,0,0,0,8'h10, 0,1,16'hBEEF};
    drive(1, 1, 0, 8'h01, 16'h0, 1, 0, 8'h02, 16'h0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) tick();
    chk("reset a_rdata", 0, s_ard[0], 16'h0);
    chk("reset b_rdata", 0, s_brd[0], 16'h0);
    chk("reset ram_addr", 0, s_addr, 8'h0);
    for (int i = 0; i < 13; i++) begin
      drive(0, tv[i].a_v, tv[i].a_we, tv[i].a_addr, tv[i].a_wd,
            tv[i].b_v, tv[i].b_we, tv[i].b_addr, tv[i].b_wd);
      tick();
      chk("tv a_ready", i, s_ar, tv[i].e_ar);
      chk("tv b_ready", i, s_br, tv[i].e_br);
      chk("tv ram_ce", i, s_ce, tv[i].e_ce);
      chk("tv ram_we", i, s_we, tv[i].e_we);
      chk("tv ram_addr", i, s_addr, tv[i].e_addr);
      chk("tv a_rvalid", i, s_arv[0], tv[i].e_arv);
      chk("tv b_rvalid", i, s_brv[0], tv[i].e_brv);
      if (tv[i].e_arv) chk("tv a_rdata", i, s_ard[0], tv[i].e_rd);
      if (tv[i].e_brv) chk("tv b_rdata", i, s_brd[0], tv[i].e_rd);
    end
    // continuous contention: grants must alternate, 4 each
    pa_addr = 8'h40; pb_addr = 8'h80; na = 0; nb = 0; prev_b = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 0, pa_addr, 16'h0, 1, 0, pb_addr, 16'h0);
      tick();
      if (i > 0) chk("alternate", i, s_br, !prev_b);
      prev_b = s_br;
      if (s_ar) begin na++; pa_addr++; end
      if (s_br) begin nb++; pb_addr++; end
    end
    chk("contention A count", 0, na, 4);
    chk("contention B count", 0, nb, 4);
    drive(0, 0, 0, 8'h0, 16'h0, 0, 0, 8'h0, 16'h0);
    for (int i = 0; i < 6; i++) tick();
    // latency sweep: write then back-to-back reads
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 1, 8'h60 + 8'(i), 16'h1000 + 16'(i), 0, 0, 8'h0, 16'h0);
      tick();
    end
    cnt = '{default: 0};
    for (int i = 0; i < 10; i++) begin
      if (i < 4) drive(0, 1, 0, 8'h60 + 8'(i), 16'h0, 0, 0, 8'h0, 16'h0);
      else drive(0, 0, 0, 8'h0, 16'h0, 0, 0, 8'h0, 16'h0);
      tick();
      for (int l = 0; l < 4; l++) if (s_arv[l]) cnt[l]++;
    end
    for (int l = 0; l < 4; l++) chk("sweep rvalid count", l+1, cnt[l], 4);
    // mid-flight reset: three reads, reset one cycle later
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 8'h61 + 8'(i), 16'h0, 0, 0, 8'h0, 16'h0);
      tick();
    end
    drive(1, 0, 0, 8'h0, 16'h0, 0, 0, 8'h0, 16'h0);
    tick();
    chk("midrst a_rvalid", 3, s_arv[2], 1'b0);
    drive(0, 0, 0, 8'h0, 16'h0, 0, 0, 8'h0, 16'h0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("midrst a_rvalid", 3, s_arv[2], 1'b0);
      chk("midrst a_rdata", 3, s_ard[2], 16'h0);
    end
    // randomized traffic with rare resets; requests hold until accepted
    ra_v = 0; rb_v = 0; ra_we = 0; rb_we = 0; ra_addr = 0; rb_addr = 0; ra_wd = 0; rb_wd = 0;
    for (int n = 0; n < 400; n++) begin
      if (!ra_v && $urandom_range(0, 2) != 0) begin
        ra_v = 1; ra_we = 1'($urandom); ra_addr = 8'($urandom_range(0, 15)); ra_wd = 16'($urandom);
      end
      if (!rb_v && $urandom_range(0, 2) != 0) begin
        rb_v = 1; rb_we = 1'($urandom); rb_addr = 8'($urandom_range(0, 15)); rb_wd = 16'($urandom);
      end
      r = ($urandom_range(0, 63) == 0);
      drive(r, ra_v, ra_we, ra_addr, ra_wd, rb_v, rb_we, rb_addr, rb_wd);
      tick();
      if (s_ar || r) ra_v = 0;
      if (s_br || r) rb_v = 0;
    end
    drive(0, 0, 0, 8'h0, 16'h0, 0, 0, 8'h0, 16'h0);
    for (int i = 0; i < 6; i++) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
